ifu_fetch_ctrl: RTL and testbench



---
 rtl/ifu_fetch_ctrl_pkg.sv | 53 +++++
 rtl/ifu_fetch_ctrl_instr_type_dec.sv | 31 +++
 rtl/ifu_fetch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_ctrl_pkg.sv
// ifu_fetch_ctrl_pkg: shared types and constants for the instruction-fetch
// sequencer and the opcode-to-format decoder.
package ifu_fetch_ctrl_pkg;

    localparam int INSTR_TYPE_W = 3;

    // Immediate-generator formats; R_TYPE doubles as "no immediate".
    typedef enum logic [INSTR_TYPE_W-1:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } instr_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [63:0] ZERO_WORD  = 64'h0;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [7:0] AXI_LEN_1BEAT  = 8'd0;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // A 64-bit beat holds two instructions; pc[2] selects the half.
    function automatic logic [31:0] pick_word(
        input logic [63:0] beat,
        input logic        hi
    );
        return hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_instr_type_dec.sv
// instr_type_dec: combinational opcode -> immediate format decoder.
// Ports: opcode_i (instr[6:0]) in, instr_type_o (format code) out.
module instr_type_dec
    import ifu_fetch_ctrl_pkg::*;
(
    input  logic [6:0]              opcode_i,
    output logic [INSTR_TYPE_W-1:0] instr_type_o
);

    always_comb begin
        instr_type_o = R_TYPE;
        unique case (opcode_i)
            OP_OP, OP_OP32:
                instr_type_o = R_TYPE;
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM:
                instr_type_o = I_TYPE;
            OP_STORE:
                instr_type_o = S_TYPE;
            OP_BRANCH:
                instr_type_o = B_TYPE;
            OP_LUI, OP_AUIPC:
                instr_type_o = U_TYPE;
            OP_JAL:
                instr_type_o = J_TYPE;
            // Unknown opcodes make the immediate generator produce zero.
            default:
                instr_type_o = R_TYPE;
        endcase
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: fetch sequencer, one single-beat AXI4 read per request.
// Ports: clock/reset (sync, active-high); core side fetch_req, pc,
// instr_ready, instr_valid, instr, instr_type, fetch_err, stall; AXI AR
// channel ar_* and R channel r_*. Optional beat buffer: FETCH_BUF_EN.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int              ID_W     = 4,
    parameter logic [ID_W-1:0] FETCH_ID = '0,
    parameter int              DATA_W   = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fetch_req,
    input  logic [63:0]             pc,
    input  logic                    instr_ready,
    output logic                    instr_valid,
    output logic [31:0]             instr,
    output logic [INSTR_TYPE_W-1:0] instr_type,
    output logic                    fetch_err,
    output logic                    stall,
    output logic                    ar_valid,
    input  logic                    ar_ready,
    output logic [63:0]             ar_addr,
    output logic [ID_W-1:0]         ar_id,
    output logic [7:0]              ar_len,
    output logic [2:0]              ar_size,
    output logic [1:0]              ar_burst,
    input  logic                    r_valid,
    output logic                    r_ready,
    input  logic [DATA_W-1:0]       r_data,
    input  logic [1:0]              r_resp,
    input  logic                    r_last,
    input  logic [ID_W-1:0]         r_id
);

    fetch_state_e state_q, state_d;

    logic [63:2] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;

    logic        misaligned;
    logic        beat_ok;
    logic        beat_err;
    logic        buf_hit;
    logic [63:0] buf_beat;

    assign misaligned = (pc[1:0] != 2'b00);
    // Beats carrying another id belong to someone else and are dropped.
    assign beat_ok  = (state_q == S_R) && r_valid && r_last &&
                      (r_id == FETCH_ID);
    assign beat_err = (r_resp != AXI_RESP_OKAY);

`ifdef FETCH_BUF_EN
    logic [63:0] buf_data_q;
    logic [63:3] buf_tag_q;
    logic        buf_vld_q;

    assign buf_hit  = buf_vld_q && (buf_tag_q == pc[63:3]);
    assign buf_beat = buf_data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_vld_q  <= 1'b0;
            buf_data_q <= ZERO_WORD;
            buf_tag_q  <= '0;
        end else if (beat_ok) begin
            if (beat_err) begin
                buf_vld_q <= 1'b0;
            end else begin
                buf_vld_q  <= 1'b1;
                buf_data_q <= r_data;
                buf_tag_q  <= pc_q[63:3];
            end
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign buf_beat = ZERO_WORD;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    if (misaligned || buf_hit) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AR: begin
                if (ar_ready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (beat_ok) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A request seen together with instr_ready waits a cycle.
                if (instr_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ar_valid    = (state_q == S_AR);
        r_ready     = (state_q == S_R);
        instr_valid = (state_q == S_DONE);
        stall       = ((state_q == S_IDLE) && fetch_req) ||
                      (state_q == S_AR) || (state_q == S_R);
    end

    // Fetch datapath: pc latch and result capture
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        err_d   = err_q;
        if ((state_q == S_IDLE) && fetch_req) begin
            if (misaligned) begin
                instr_d = NOP;
                err_d   = 1'b1;
            end else begin
                pc_d = pc[63:2];
                if (buf_hit) begin
                    instr_d = pick_word(buf_beat, pc[2]);
                    err_d   = 1'b0;
                end
            end
        end
        if (beat_ok) begin
            err_d   = beat_err;
            instr_d = beat_err ? NOP : pick_word(r_data, pc_q[2]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= '0;
            instr_q <= NOP;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    instr_type_dec u_type_dec (
        .opcode_i     (instr_q[6:0]),
        .instr_type_o (instr_type)
    );

    assign instr     = instr_q;
    assign fetch_err = err_q;
    assign ar_addr   = {pc_q[63:3], 3'b000};
    assign ar_id     = FETCH_ID;
    assign ar_len    = AXI_LEN_1BEAT;
    assign ar_size   = AXI_SIZE_8B;
    assign ar_burst  = AXI_BURST_INCR;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: table vectors, corner sequences and randomized fetches
// checked against a transaction-level model of the fetch sequencer.
module tb_ifu_fetch_ctrl;
    import ifu_fetch_ctrl_pkg::*;

    localparam int ID_W = 4;

`ifdef FETCH_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            fetch_req = 1'b0;
    logic [63:0]     pc = 64'h0;
    logic            instr_ready = 1'b0;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [2:0]      instr_type;
    logic            fetch_err;
    logic            stall;
    logic            ar_valid;
    logic            ar_ready = 1'b0;
    logic [63:0]     ar_addr;
    logic [ID_W-1:0] ar_id;
    logic [7:0]      ar_len;
    logic [2:0]      ar_size;
    logic [1:0]      ar_burst;
    logic            r_valid = 1'b0;
    logic            r_ready;
    logic [63:0]     r_data = 64'h0;
    logic [1:0]      r_resp = 2'b00;
    logic            r_last = 1'b0;
    logic [ID_W-1:0] r_id = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    ifu_fetch_ctrl #(.ID_W(ID_W), .FETCH_ID('0), .DATA_W(64)) dut (
        .clock(clock), .reset(reset), .fetch_req(fetch_req), .pc(pc),
        .instr_ready(instr_ready), .instr_valid(instr_valid),
        .instr(instr), .instr_type(instr_type), .fetch_err(fetch_err),
        .stall(stall), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst), .r_valid(r_valid),
        .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .r_last(r_last), .r_id(r_id)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] rdata;
        logic [1:0]  resp;
        int          ar_dly;
        int          r_dly;
        int          junk;
        int          rdy;
        logic [31:0] e_instr;
        logic [2:0]  e_ty;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  ty;
        logic        err;
        int          lat;
        bit          saw_ar;
        bit          ar_bad;
        bit          stall_bad;
        bit          hold_bad;
        bit          timeout;
        logic        post_iv;
        logic        post_stall;
    } obs_t;

    localparam logic [6:0] OPS [12] = '{
        7'b0110011, 7'b0111011, 7'b0000011, 7'b0010011, 7'b0011011,
        7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111,
        7'b0010111, 7'b1101111
    };
    localparam logic [2:0] OPT [12] = '{
        R_TYPE, R_TYPE, I_TYPE, I_TYPE, I_TYPE, I_TYPE, I_TYPE,
        S_TYPE, B_TYPE, U_TYPE, U_TYPE, J_TYPE
    };

    logic [63:0] memq [logic [63:0]];

    logic        m_vld = 1'b0;
    logic [60:0] m_tag = '0;
    logic [63:0] m_data = '0;

    function automatic logic [2:0] ref_type(input logic [31:0] w);
        logic [2:0] t;
        t = R_TYPE;
        for (int k = 0; k < 12; k++) begin
            if (OPS[k] == w[6:0]) t = OPT[k];
        end
        return t;
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 12);
        if (k < 12) w[6:0] = OPS[k];
        return w;
    endfunction

    task automatic get_mem(input logic [63:0] a, output logic [63:0] d);
        if (!memq.exists(a)) memq[a] = {rnd_word(), rnd_word()};
        d = memq[a];
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: outcome of one fetch from the rules alone.
    task automatic model(input logic [63:0] p, input logic [63:0] rdata,
                         input logic [1:0] resp, input int dly,
                         output logic [31:0] e_i, output logic e_e,
                         output int e_lat, output bit e_ar);
        logic [63:0] beat;
        e_ar  = 1'b0;
        e_lat = 1;
        if (p[1:0] != 2'd0) begin
            e_i = NOP;
            e_e = 1'b1;
        end else if (BUF_EN && m_vld && m_tag == p[63:3]) begin
            beat = m_data >> (p[2] ? 32 : 0);
            e_i  = beat[31:0];
            e_e  = 1'b0;
        end else begin
            e_ar  = 1'b1;
            e_lat = 3 + dly;
            if (resp != 2'b00) begin
                e_i   = NOP;
                e_e   = 1'b1;
                m_vld = 1'b0;
            end else begin
                beat   = rdata >> (p[2] ? 32 : 0);
                e_i    = beat[31:0];
                e_e    = 1'b0;
                m_vld  = 1'b1;
                m_tag  = p[63:3];
                m_data = rdata;
            end
        end
    endtask

    // Acts as core and AXI slave for one fetch, recording what it saw.
    task automatic run_fetch(input logic [63:0] p, input logic [63:0] rdata,
                             input logic [1:0] resp, input int ar_dly,
                             input int r_dly, input int junk, input int rdy,
                             output obs_t o);
        int  ar_w, r_w, jl, vw;
        bit  fin;
        o = '{instr: 0, ty: 0, err: 0, lat: -1, saw_ar: 0, ar_bad: 0,
              stall_bad: 0, hold_bad: 0, timeout: 0, post_iv: 0,
              post_stall: 0};
        ar_w = 0; r_w = 0; jl = junk; vw = 0; fin = 1'b0;
        @(posedge clock); #1;
        fetch_req = 1'b1;
        pc = p;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clock);
            if (instr_valid) begin
                if (o.lat < 0) begin
                    o.lat = cyc;
                    o.instr = instr;
                    o.ty = instr_type;
                    o.err = fetch_err;
                    fetch_req = 1'b0;
                end else if ({instr, instr_type, fetch_err} !==
                             {o.instr, o.ty, o.err}) begin
                    o.hold_bad = 1'b1;
                end
                if (stall !== 1'b0) o.stall_bad = 1'b1;
                if (vw == rdy) begin
                    instr_ready = 1'b1;
                    fin = 1'b1;
                end else begin
                    vw++;
                end
            end else if (stall !== 1'b1) begin
                o.stall_bad = 1'b1;
            end
            ar_ready = 1'b0;
            if (ar_valid) begin
                o.saw_ar = 1'b1;
                if (ar_addr !== {p[63:3], 3'b000}) o.ar_bad = 1'b1;
                if (ar_w == ar_dly) ar_ready = 1'b1;
                else ar_w++;
                pc = {$urandom, $urandom};
            end
            r_valid = 1'b0;
            r_last = 1'b0;
            if (r_ready) begin
                pc = {$urandom, $urandom};
                if (r_w < r_dly) begin
                    r_w++;
                end else if (jl > 0) begin
                    r_valid = 1'b1; r_last = 1'b1; r_id = 4'h5;
                    r_data = {$urandom, $urandom}; r_resp = 2'b00;
                    jl--;
                end else begin
                    r_valid = 1'b1; r_last = 1'b1; r_id = '0;
                    r_data = rdata; r_resp = resp;
                end
            end
        end
        o.timeout = !fin;
        @(posedge clock); #1;
        instr_ready = 1'b0;
        fetch_req = 1'b0;
        ar_ready = 1'b0;
        r_valid = 1'b0;
        if (!fin) begin
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            m_vld = 1'b0;
        end
        @(negedge clock);
        o.post_iv = instr_valid;
        o.post_stall = stall;
    endtask

    task automatic check_obs(input string nm, input obs_t o,
                             input logic [31:0] e_i, input logic e_e,
                             input int e_lat, input bit e_ar);
        chk({nm, " timeout"}, o.timeout, 0);
        chk({nm, " instr"}, o.instr, e_i);
        chk({nm, " type"}, o.ty, ref_type(e_i));
        chk({nm, " err"}, o.err, e_e);
        chk({nm, " latency"}, o.lat, e_lat);
        chk({nm, " ar_issued"}, o.saw_ar, e_ar);
        chk({nm, " ar_addr"}, o.ar_bad, 0);
        chk({nm, " stall"}, o.stall_bad, 0);
        chk({nm, " hold"}, o.hold_bad, 0);
        chk({nm, " idle_valid"}, o.post_iv, 0);
        chk({nm, " idle_stall"}, o.post_stall, 0);
    endtask

    vec_t tbl [11];

    initial begin
        obs_t        o;
        logic [31:0] e_i;
        logic        e_e;
        int          e_lat;
        bit          e_ar;
        bit          got;

        tbl[0]  = '{64'h8000_0004, 64'h00A00093_00000013, 2'b00, 0, 0, 0, 0,
                    32'h00A00093, I_TYPE, 1'b0};
        tbl[1]  = '{64'h8000_0000, 64'h00A00093_00000013, 2'b00, 0, 0, 0, 1,
                    32'h00000013, I_TYPE, 1'b0};
        tbl[2]  = '{64'h8000_0010, 64'h00112023_00208233, 2'b00, 5, 2, 0, 0,
                    32'h00208233, R_TYPE, 1'b0};
        tbl[3]  = '{64'h8000_0014, 64'h00112023_00208233, 2'b00, 0, 1, 0, 4,
                    32'h00112023, S_TYPE, 1'b0};
        tbl[4]  = '{64'h8000_0020, 64'h00208063_008000EF, 2'b00, 1, 0, 2, 0,
                    32'h008000EF, J_TYPE, 1'b0};
        tbl[5]  = '{64'h8000_0104, 64'h00208063_008000EF, 2'b10, 0, 0, 0, 3,
                    NOP, I_TYPE, 1'b1};
        tbl[6]  = '{64'h8000_0002, 64'h0, 2'b00, 0, 0, 0, 0,
                    NOP, I_TYPE, 1'b1};
        tbl[7]  = '{64'h8000_0204, 64'h00000517_12345037, 2'b00, 2, 0, 1, 2,
                    32'h00000517, U_TYPE, 1'b0};
        tbl[8]  = '{64'h8000_0300, 64'h00208063_00208063, 2'b11, 0, 3, 0, 0,
                    NOP, I_TYPE, 1'b1};
        tbl[9]  = '{64'h8000_0303, 64'h0, 2'b00, 0, 0, 0, 1,
                    NOP, I_TYPE, 1'b1};
        tbl[10] = '{64'h8000_0400, 64'h00208063_FFFFFFFF, 2'b00, 0, 0, 0, 0,
                    32'hFFFFFFFF, R_TYPE, 1'b0};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst instr_valid", instr_valid, 0);
        chk("rst fetch_err", fetch_err, 0);
        chk("rst ar_valid", ar_valid, 0);
        chk("rst r_ready", r_ready, 0);
        chk("rst stall", stall, 0);
        chk("rst instr", instr, NOP);
        chk("rst instr_type", instr_type, I_TYPE);
        chk("rst ar_addr", ar_addr, 0);
        chk("ar_id", ar_id, 0);
        chk("ar_len", ar_len, 0);
        chk("ar_size", ar_size, 3'b011);
        chk("ar_burst", ar_burst, 2'b01);

        for (int i = 0; i < 11; i++) begin
            model(tbl[i].pc, tbl[i].rdata, tbl[i].resp,
                  tbl[i].ar_dly + tbl[i].r_dly + tbl[i].junk,
                  e_i, e_e, e_lat, e_ar);
            run_fetch(tbl[i].pc, tbl[i].rdata, tbl[i].resp, tbl[i].ar_dly,
                      tbl[i].r_dly, tbl[i].junk, tbl[i].rdy, o);
            check_obs($sformatf("vec%0d", i), o, tbl[i].e_instr,
                      tbl[i].e_err, e_lat, e_ar);
            chk($sformatf("vec%0d table_type", i), o.ty, tbl[i].e_ty);
        end

        // Reset while waiting in AR (s=0) and in R (s=1).
        for (int s = 0; s < 2; s++) begin
            @(posedge clock); #1;
            fetch_req = 1'b1;
            pc = 64'h8000_0800;
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clock);
                got = (s == 0) ? ar_valid : r_ready;
                if (s == 1) ar_ready = ar_valid;
            end
            chk($sformatf("midrst%0d reach", s), got, 1);
            ar_ready = 1'b0;
            reset = 1'b1;
            fetch_req = 1'b0;
            @(posedge clock); #1;
            reset = 1'b0;
            m_vld = 1'b0;
            @(negedge clock);
            chk($sformatf("midrst%0d ar_valid", s), ar_valid, 0);
            chk($sformatf("midrst%0d r_ready", s), r_ready, 0);
            chk($sformatf("midrst%0d stall", s), stall, 0);
            chk($sformatf("midrst%0d instr_valid", s), instr_valid, 0);
            chk($sformatf("midrst%0d instr", s), instr, NOP);
        end

        for (int i = 0; i < 150; i++) begin
            logic [63:0] p, rd;
            logic [1:0]  rs;
            int          ad, rdl, jk, ry;
            p = 64'h8000_0000 + 64'(8 * $urandom_range(0, 7)) +
                64'(4 * $urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) p = p + 64'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) p = {$urandom, $urandom} & ~64'h3;
            rs = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ad = $urandom_range(0, 3);
            rdl = $urandom_range(0, 3);
            jk = $urandom_range(0, 2);
            ry = $urandom_range(0, 3);
            get_mem({p[63:3], 3'b000}, rd);
            model(p, rd, rs, ad + rdl + jk, e_i, e_e, e_lat, e_ar);
            run_fetch(p, rd, rs, ad, rdl, jk, ry, o);
            check_obs($sformatf("rnd%0d", i), o, e_i, e_e, e_lat, e_ar);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
